// File: rtl/ltc2333_conv_sequencer_if.sv
// LTC2333 conversion/readback pin bundle.
// master: cnv, scki, sdi out, busy in; slave: mirror.
interface ltc2333_conv_sequencer_if;
  logic cnv;
  logic scki;
  logic sdi;
  logic busy;

  modport master (
    output cnv,
    output scki,
    output sdi,
    input  busy
  );

  modport slave (
    input  cnv,
    input  scki,
    input  sdi,
    output busy
  );
endinterface

// File: rtl/ltc2333_conv_sequencer.sv
// LTC2333 conversion sequencer: CNV, BUSY wait, SCKI frame, SDI word.
// Ports: clk, reset (async, high), enable, period, n_slot,
// slot_chan, slot_span, adc (cnv/scki/sdi/busy), slot_idx,
// frame_done, overrun, busy_tmo, running.
module ltc2333_conv_sequencer #(
  parameter int CLK_DIV    = 2,
  parameter int CNV_HIGH   = 4,
  parameter int BUSY_TMO   = 512,
  parameter int SCK_CYCLES = 12,
  parameter int N_SLOT     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [15:0]         period,
  input  logic [2:0]          n_slot,
  input  logic [N_SLOT*3-1:0] slot_chan,
  input  logic [N_SLOT*3-1:0] slot_span,
  ltc2333_conv_sequencer_if.master adc,
  output logic [2:0]          slot_idx,
  output logic                frame_done,
  output logic                overrun,
  output logic                busy_tmo,
  output logic                running
);

  localparam int TMAX =
    (BUSY_TMO > CNV_HIGH) ? BUSY_TMO : CNV_HIGH;
  localparam int TW = $clog2(TMAX + 1);
  localparam int DW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(SCK_CYCLES + 1);

  localparam logic [TW-1:0] CNV_LAST = TW'(CNV_HIGH - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TMO - 1);
  localparam logic [TW-1:0] MIN_WAIT = TW'(2);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] SCK_LAST = BW'(SCK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNV_HI,
    S_WAIT_BSY,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t        state, state_d;
  logic [15:0]   cnt, cnt_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic [DW-1:0] dcnt, dcnt_d;
  logic [BW-1:0] bcnt, bcnt_d;
  logic          sck_q, sck_d;
  logic          cnv_q, cnv_d;
  logic [7:0]    sreg, sreg_d;
  logic [2:0]    ptr, ptr_d;
  logic [2:0]    slot_d;
  logic          fdone_d;
  logic          ovr_d;
  logic          tmo_d;
  logic          bs1, bs2;
  logic          start;
  logic          bsy_done;
  logic [2:0]    nxt;
  logic [7:0]    nxt_word;
  logic [15:0]   per_ld;

  // A pointer left beyond a shrunken list wraps at its next advance.
  assign nxt = (ptr >= n_slot) ? 3'd0 : ptr + 3'd1;

  assign nxt_word = {1'b1,
                     slot_chan[nxt*3 +: 3],
                     slot_span[nxt*3 +: 3],
                     1'b0};

  assign per_ld = (period == 16'd0) ? 16'd0
                                    : period - 16'd1;

  assign bsy_done = (tcnt >= MIN_WAIT) && !bs2;

  assign adc.cnv  = cnv_q;
  assign adc.scki = sck_q;
  assign adc.sdi  = sreg[7];
  assign running  = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bs1 <= 1'b0;
      bs2 <= 1'b0;
    end else begin
      bs1 <= adc.busy;
      bs2 <= bs1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      tcnt       <= '0;
      dcnt       <= '0;
      bcnt       <= '0;
      sck_q      <= 1'b0;
      cnv_q      <= 1'b0;
      sreg       <= '0;
      ptr        <= '0;
      slot_idx   <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      busy_tmo   <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      tcnt       <= tcnt_d;
      dcnt       <= dcnt_d;
      bcnt       <= bcnt_d;
      sck_q      <= sck_d;
      cnv_q      <= cnv_d;
      sreg       <= sreg_d;
      ptr        <= ptr_d;
      slot_idx   <= slot_d;
      frame_done <= fdone_d;
      overrun    <= ovr_d;
      busy_tmo   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = (cnt != 16'd0) ? cnt - 16'd1 : cnt;
    tcnt_d  = tcnt + 1'b1;
    dcnt_d  = dcnt;
    bcnt_d  = bcnt;
    sck_d   = sck_q;
    cnv_d   = cnv_q;
    sreg_d  = sreg;
    ptr_d   = ptr;
    slot_d  = slot_idx;
    fdone_d = 1'b0;
    ovr_d   = overrun;
    tmo_d   = busy_tmo;
    start   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (enable) start = 1'b1;
      end
      S_CNV_HI: begin
        if (tcnt == CNV_LAST) begin
          state_d = S_WAIT_BSY;
          cnv_d   = 1'b0;
          tcnt_d  = '0;
        end
      end
      S_WAIT_BSY: begin
        if (bsy_done || tcnt == TMO_LAST) begin
          if (!bsy_done) tmo_d = 1'b1;
          state_d = S_SHIFT;
          sreg_d  = nxt_word;
          sck_d   = 1'b0;
          dcnt_d  = '0;
          bcnt_d  = '0;
        end
      end
      S_SHIFT: begin
        if (dcnt == DIV_LAST) begin
          dcnt_d = '0;
          sck_d  = !sck_q;
          // Falling SCKI edge: next SDI bit or end of frame.
          if (sck_q) begin
            if (bcnt == SCK_LAST) begin
              state_d = S_GAP;
              sck_d   = 1'b0;
              sreg_d  = '0;
              fdone_d = 1'b1;
              ptr_d   = nxt;
            end else begin
              bcnt_d = bcnt + 1'b1;
              sreg_d = {sreg[6:0], 1'b0};
            end
          end
        end else begin
          dcnt_d = dcnt + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == 16'd0) begin
          if (enable) start   = 1'b1;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d = S_CNV_HI;
      cnt_d   = per_ld;
      cnv_d   = 1'b1;
      tcnt_d  = '0;
      slot_d  = ptr;
    end

    // Sample period expired while a frame was still in flight.
    if (cnt == 16'd0 &&
        (state == S_CNV_HI ||
         state == S_WAIT_BSY ||
         state == S_SHIFT))
      ovr_d = 1'b1;

    if (!enable) begin
      ovr_d = 1'b0;
      tmo_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_ltc2333_conv_sequencer.sv
// Directed bench for ltc2333_conv_sequencer.
// BUSY model: high 30 cycles after each CNV rise, or stuck high.
module tb_ltc2333_conv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] period = 16'd200;
  logic [2:0]  n_slot = 3'd0;
  logic [23:0] slot_chan = '0;
  logic [23:0] slot_span = '0;
  logic [2:0]  slot_idx;
  logic        frame_done;
  logic        overrun;
  logic        busy_tmo;
  logic        running;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit busy_stuck = 1'b0;

  int          fr_tc [4];
  int          fr_td [4];
  int          fr_ns [4];
  logic [11:0] fr_bits [4];
  logic [2:0]  fr_sidx [4];
  bit          fr_ok [4];

  ltc2333_conv_sequencer_if ifc ();

  ltc2333_conv_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .period     (period),
    .n_slot     (n_slot),
    .slot_chan  (slot_chan),
    .slot_span  (slot_span),
    .adc        (ifc),
    .slot_idx   (slot_idx),
    .frame_done (frame_done),
    .overrun    (overrun),
    .busy_tmo   (busy_tmo),
    .running    (running)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    ifc.busy = 1'b0;
    forever begin
      @(posedge ifc.cnv);
      #1 ifc.busy = 1'b1;
      if (!busy_stuck) begin
        repeat (30) @(posedge clk);
        #1 ifc.busy = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic grab(output int tc, output int td,
                      output int ns,
                      output logic [11:0] bits,
                      output logic [2:0] sidx,
                      output bit ok);
    logic pc, ps;
    bit got;
    ok = 1'b0; ns = 0; bits = '0; sidx = '0;
    tc = 0; td = 0; got = 1'b0;
    pc = ifc.cnv;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (ifc.cnv && !pc) begin
        got = 1'b1;
        tc = cyc;
      end
      pc = ifc.cnv;
    end
    if (!got) return;
    ps = ifc.scki;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ifc.scki && !ps) begin
        if (ns < 12) bits[11-ns] = ifc.sdi;
        ns++;
      end
      ps = ifc.scki;
      if (frame_done) begin
        sidx = slot_idx;
        td = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({ifc.cnv, ifc.scki, ifc.sdi} !== 3'b000) begin
      failures++;
      $display("FAIL rst_pins got=%b want=000",
               {ifc.cnv, ifc.scki, ifc.sdi});
    end
    checks++;
    if ({frame_done, overrun, busy_tmo, running} !== 4'b0) begin
      failures++;
      $display("FAIL rst_flags got=%b want=0000",
               {frame_done, overrun, busy_tmo, running});
    end
    checks++;
    if (slot_idx !== 3'd0) begin
      failures++;
      $display("FAIL rst_slot got=%0d want=0", slot_idx);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({running, ifc.cnv} !== 2'b00) begin
      failures++;
      $display("FAIL idle_disabled got=%b want=00",
               {running, ifc.cnv});
    end
  endtask

  task automatic test_sequence;
    int exp_sidx [4] = '{0, 1, 2, 0};
    period = 16'd200;
    n_slot = 3'd2;
    slot_chan[2:0] = 3'd2; slot_span[2:0] = 3'd7;
    slot_chan[5:3] = 3'd5; slot_span[5:3] = 3'd3;
    slot_chan[8:6] = 3'd6; slot_span[8:6] = 3'd1;
    @(negedge clk);
    enable = 1'b1;
    for (int k = 0; k < 4; k++)
      grab(fr_tc[k], fr_td[k], fr_ns[k],
           fr_bits[k], fr_sidx[k], fr_ok[k]);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!fr_ok[k]) begin
        failures++;
        $display("FAIL seq_frame%0d got=timeout want=done", k);
      end
      checks++;
      if (fr_ns[k] !== 12) begin
        failures++;
        $display("FAIL seq_sck%0d got=%0d want=12",
                 k, fr_ns[k]);
      end
      checks++;
      if (int'(fr_sidx[k]) !== exp_sidx[k]) begin
        failures++;
        $display("FAIL seq_slot%0d got=%0d want=%0d",
                 k, fr_sidx[k], exp_sidx[k]);
      end
      checks++;
      if (fr_td[k] - fr_tc[k] !== 81) begin
        failures++;
        $display("FAIL seq_latency%0d got=%0d want=81",
                 k, fr_td[k] - fr_tc[k]);
      end
    end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (fr_tc[k] - fr_tc[k-1] !== 200) begin
        failures++;
        $display("FAIL seq_spacing%0d got=%0d want=200",
                 k, fr_tc[k] - fr_tc[k-1]);
      end
    end
    checks++;
    if ({overrun, busy_tmo} !== 2'b00) begin
      failures++;
      $display("FAIL seq_flags got=%b want=00",
               {overrun, busy_tmo});
    end
  endtask

  task automatic test_sdi_word;
    logic [11:0] exp_bits [4] =
      '{12'hD60, 12'hE20, 12'hAE0, 12'hD60};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (fr_bits[k] !== exp_bits[k]) begin
        failures++;
        $display("FAIL sdi_word%0d got=%h want=%h",
                 k, fr_bits[k], exp_bits[k]);
      end
    end
  endtask

  task automatic test_overrun;
    int tc [3];
    int td [3];
    int ns [3];
    logic [11:0] bits [3];
    logic [2:0] sidx [3];
    bit ok [3];
    int exp_sidx [3] = '{1, 0, 0};
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 400 && running; i++) @(negedge clk);
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL ovr_idle got=%b want=0", running);
    end
    period = 16'd50;
    n_slot = 3'd0;
    enable = 1'b1;
    grab(tc[0], td[0], ns[0], bits[0], sidx[0], ok[0]);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_flag got=%b want=1", overrun);
    end
    grab(tc[1], td[1], ns[1], bits[1], sidx[1], ok[1]);
    grab(tc[2], td[2], ns[2], bits[2], sidx[2], ok[2]);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (!ok[k] || ns[k] !== 12) begin
        failures++;
        $display("FAIL ovr_frame%0d got=ok%0d/sck%0d want=ok1/sck12",
                 k, ok[k], ns[k]);
      end
      checks++;
      if (int'(sidx[k]) !== exp_sidx[k]) begin
        failures++;
        $display("FAIL ovr_slot%0d got=%0d want=%0d",
                 k, sidx[k], exp_sidx[k]);
      end
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (tc[k] - tc[k-1] !== 82) begin
        failures++;
        $display("FAIL ovr_spacing%0d got=%0d want=82",
                 k, tc[k] - tc[k-1]);
      end
    end
  endtask

  task automatic test_enable_drop;
    logic pc, ps;
    bit got, seen, hi;
    int ns;
    got = 1'b0; seen = 1'b0; hi = 1'b0; ns = 0;
    pc = ifc.cnv;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (ifc.cnv && !pc) got = 1'b1;
      pc = ifc.cnv;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL drop_cnv got=none want=cnv_rise");
    end
    ps = ifc.scki;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (ifc.scki && !ps) begin
        ns++;
        if (ns == 3) enable = 1'b0;
      end
      ps = ifc.scki;
      if (frame_done) seen = 1'b1;
    end
    checks++;
    if (!seen || ns !== 12) begin
      failures++;
      $display("FAIL drop_frame got=done%0d/sck%0d want=done1/sck12",
               seen, ns);
    end
    checks++;
    if ({overrun, busy_tmo} !== 2'b00) begin
      failures++;
      $display("FAIL drop_flags got=%b want=00",
               {overrun, busy_tmo});
    end
    for (int i = 0; i < 400 && running; i++) @(negedge clk);
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL drop_idle got=%b want=0", running);
    end
    repeat (100) begin
      @(negedge clk);
      if (ifc.cnv) hi = 1'b1;
    end
    checks++;
    if (hi) begin
      failures++;
      $display("FAIL drop_quiet got=cnv_high want=cnv_low");
    end
  endtask

  task automatic test_busy_timeout;
    int tc, td, ns;
    logic [11:0] bits;
    logic [2:0] sidx;
    bit ok;
    busy_stuck = 1'b1;
    period = 16'd1000;
    @(negedge clk);
    enable = 1'b1;
    grab(tc, td, ns, bits, sidx, ok);
    checks++;
    if (!ok || ns !== 12) begin
      failures++;
      $display("FAIL tmo_frame got=ok%0d/sck%0d want=ok1/sck12",
               ok, ns);
    end
    checks++;
    if (td - tc !== 564) begin
      failures++;
      $display("FAIL tmo_latency got=%0d want=564", td - tc);
    end
    checks++;
    if ({busy_tmo, overrun} !== 2'b10) begin
      failures++;
      $display("FAIL tmo_flags got=%b want=10",
               {busy_tmo, overrun});
    end
    enable = 1'b0;
    for (int i = 0; i < 2000 && running; i++) @(negedge clk);
    checks++;
    if ({running, busy_tmo} !== 2'b00) begin
      failures++;
      $display("FAIL tmo_idle got=%b want=00",
               {running, busy_tmo});
    end
  endtask

  task automatic test_reset_mid;
    int tc, td, ns;
    logic [11:0] bits;
    logic [2:0] sidx;
    bit ok, got;
    busy_stuck = 1'b0;
    period = 16'd200;
    n_slot = 3'd2;
    @(negedge clk);
    enable = 1'b1;
    grab(tc, td, ns, bits, sidx, ok);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (ifc.cnv) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rmid_cnv got=none want=cnv_high");
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ifc.cnv, ifc.scki, ifc.sdi, running} !== 4'b0) begin
      failures++;
      $display("FAIL rmid_async got=%b want=0000",
               {ifc.cnv, ifc.scki, ifc.sdi, running});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    grab(tc, td, ns, bits, sidx, ok);
    checks++;
    if (!ok || sidx !== 3'd0) begin
      failures++;
      $display("FAIL rmid_slot got=ok%0d/slot%0d want=ok1/slot0",
               ok, sidx);
    end
    checks++;
    if (bits !== 12'hD60) begin
      failures++;
      $display("FAIL rmid_word got=%h want=d60", bits);
    end
  endtask

  initial begin
    test_reset;
    test_sequence;
    test_sdi_word;
    test_overrun;
    test_enable_drop;
    test_busy_timeout;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
